// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction fetch (I) and data (D) share one memory port.
// One access runs at a time through IDLE -> I/D BUSY -> RESP -> IDLE.
// Define MEM_ARB_FAIR_EN to break simultaneous-request ties against the last grant.
// With it undefined, the data port wins every tie.
module mem_arbiter #(
  parameter int unsigned N = 64,
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ireq,
  input  logic [W-1:0] iadr,
  output logic         iready,
  output logic [W-1:0] irdata,
  input  logic         dreq,
  input  logic         dwe,
  input  logic [N-1:0] dadr,
  input  logic [N-1:0] dwdata,
  output logic         dready,
  output logic [N-1:0] drdata,
  output logic         mreq,
  output logic         mwe,
  output logic [W-1:0] madr,
  output logic [N-1:0] mwdata,
  input  logic         mack,
  input  logic [N-1:0] mrdata,
  output logic         stallF,
  output logic         stallM
);

  typedef enum logic [1:0] {StIdle, StIBusy, StDBusy, StResp} state_e;

  state_e r_state;
  state_e w_state_next;
  logic   r_lastgrant_d;  // 1: last grant went to D, 0: to I
  logic   r_served_d;     // port whose access is in flight / responding
  logic   w_grant_i;
  logic   w_grant_d;
  logic   w_unused;

  // Arbitration and next-state decode; grants only happen from IDLE.
  always_comb begin
    w_state_next = r_state;
    w_grant_i    = 1'b0;
    w_grant_d    = 1'b0;
    unique case (r_state)
      StIdle: begin
`ifdef MEM_ARB_FAIR_EN
        if (ireq && dreq) begin
          w_grant_i = r_lastgrant_d;
          w_grant_d = !r_lastgrant_d;
        end else begin
          w_grant_i = ireq;
          w_grant_d = dreq;
        end
`else
        w_grant_d = dreq;
        w_grant_i = ireq && !dreq;
`endif
        if (w_grant_d) begin
          w_state_next = StDBusy;
        end else if (w_grant_i) begin
          w_state_next = StIBusy;
        end
      end
      StIBusy, StDBusy: begin
        if (mack) begin
          w_state_next = StResp;
        end
      end
      StResp: begin
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // State, registered memory request fields and captured read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= StIdle;
      r_lastgrant_d <= 1'b1;
      r_served_d    <= 1'b0;
      madr          <= '0;
      mwe           <= 1'b0;
      mwdata        <= '0;
      irdata        <= '0;
      drdata        <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_grant_d) begin
        madr          <= dadr[W-1:0];
        mwe           <= dwe;
        mwdata        <= dwdata;
        r_lastgrant_d <= 1'b1;
        r_served_d    <= 1'b1;
      end else if (w_grant_i) begin
        madr          <= iadr;
        mwe           <= 1'b0;
        r_lastgrant_d <= 1'b0;
        r_served_d    <= 1'b0;
      end
      if (r_state == StIBusy && mack) begin
        irdata <= mrdata[W-1:0];
      end
      if (r_state == StDBusy && mack) begin
        drdata <= mrdata;
      end
    end
  end

  assign mreq   = (r_state == StIBusy) || (r_state == StDBusy);
  assign iready = (r_state == StResp) && !r_served_d;
  assign dready = (r_state == StResp) && r_served_d;
  assign stallF = ireq && !iready;
  assign stallM = dreq && !dready;

  // Upper data-address bits are not part of the memory address.
`ifdef MEM_ARB_FAIR_EN
  assign w_unused = ^dadr[N-1:W];
`else
  assign w_unused = ^{dadr[N-1:W], r_lastgrant_d};
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed fetch/store/wait/reset cases plus
// randomized single and colliding requests checked against a transaction-level model.
module tb_mem_arbiter;
  localparam int N = 64;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         ireq;
  logic [W-1:0] iadr;
  logic         iready;
  logic [W-1:0] irdata;
  logic         dreq;
  logic         dwe;
  logic [N-1:0] dadr;
  logic [N-1:0] dwdata;
  logic         dready;
  logic [N-1:0] drdata;
  logic         mreq;
  logic         mwe;
  logic [W-1:0] madr;
  logic [N-1:0] mwdata;
  logic         mack;
  logic [N-1:0] mrdata;
  logic         stallF;
  logic         stallM;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: who was granted last, and what each read-data port should be holding.
  bit           m_last_d = 1'b1;
  logic [W-1:0] m_irdata = '0;
  logic [N-1:0] m_drdata = '0;

  mem_arbiter #(.N(N), .W(W)) dut (
    .clk(clk), .reset(reset),
    .ireq(ireq), .iadr(iadr), .iready(iready), .irdata(irdata),
    .dreq(dreq), .dwe(dwe), .dadr(dadr), .dwdata(dwdata), .dready(dready), .drdata(drdata),
    .mreq(mreq), .mwe(mwe), .madr(madr), .mwdata(mwdata),
    .mack(mack), .mrdata(mrdata), .stallF(stallF), .stallM(stallM)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Which port a tie in IDLE should go to, from the arbitration rule.
  function automatic bit tie_winner_d();
`ifdef MEM_ARB_FAIR_EN
    return !m_last_d;
`else
    return 1'b1;
`endif
  endfunction

  // One access: called in IDLE with the requester's req already high; the next edge grants.
  task automatic serve(input bit is_d, input int wt, input logic [N-1:0] rd, input bit drop);
    logic [W-1:0] exp_adr;
    tick();
    exp_adr = is_d ? dadr[W-1:0] : iadr;
    check("grant_mreq", mreq, 1);
    check("grant_madr", madr, exp_adr);
    check("grant_mwe", mwe, is_d ? dwe : 1'b0);
    if (is_d) check("grant_mwdata", mwdata, dwdata);
    check("busy_stallF", stallF, ireq);
    check("busy_stallM", stallM, dreq);
    m_last_d = is_d;
    for (int k = 0; k < wt; k++) begin
      tick();
      check("wait_mreq", mreq, 1);
      check("wait_madr", madr, exp_adr);
      check("wait_mwe", mwe, is_d ? dwe : 1'b0);
      if (is_d) check("wait_mwdata", mwdata, dwdata);
      check("wait_ready", {iready, dready}, 2'b00);
    end
    mrdata = rd;
    mack   = 1'b1;
    tick();
    mack   = 1'b0;
    mrdata = {$urandom, $urandom};
    if (is_d) m_drdata = rd;
    else m_irdata = rd[W-1:0];
    check("resp_mreq", mreq, 0);
    check("resp_iready", iready, !is_d);
    check("resp_dready", dready, is_d);
    check("resp_irdata", irdata, m_irdata);
    check("resp_drdata", drdata, m_drdata);
    check("resp_stallF", stallF, ireq && is_d);
    check("resp_stallM", stallM, dreq && !is_d);
    if (drop) begin
      if (is_d) dreq = 1'b0;
      else ireq = 1'b0;
    end
    tick();
    check("post_ready", {iready, dready}, 2'b00);
    check("post_mreq", mreq, 0);
    check("hold_irdata", irdata, m_irdata);
    check("hold_drdata", drdata, m_drdata);
  endtask

  initial begin
    bit ri;
    bit rq;
    bit first_d;

    reset = 1'b1; ireq = 0; iadr = '0; dreq = 0; dwe = 0; dadr = '0; dwdata = '0;
    mack = 0; mrdata = '0;
    tick();
    tick();
    check("rst_mreq", mreq, 0);
    check("rst_mwe", mwe, 0);
    check("rst_madr", madr, 0);
    check("rst_mwdata", mwdata, 0);
    check("rst_ready", {iready, dready}, 2'b00);
    check("rst_irdata", irdata, 0);
    check("rst_drdata", drdata, 0);
    reset = 1'b0;
    tick();

    // Fetch with one wait cycle.
    ireq = 1'b1; iadr = 32'h0000_0040;
    serve(1'b0, 1, 64'h0000_0000_2008_0005, 1'b1);
    check("fetch_irdata", irdata, 32'h2008_0005);

    // Store with four wait cycles.
    dreq = 1'b1; dwe = 1'b1; dadr = 64'h80; dwdata = 64'h1122_3344_5566_7788;
    serve(1'b1, 4, {$urandom, $urandom}, 1'b1);
    dwe = 1'b0;

    // Zero-wait access: ready three cycles after the request appears.
    dreq = 1'b1; dadr = {$urandom, $urandom};
    serve(1'b1, 0, {$urandom, $urandom}, 1'b1);

    // Both held high: fixed priority serves D every time, fair mode alternates.
    ireq = 1'b1; iadr = $urandom; dreq = 1'b1; dadr = {$urandom, $urandom};
    dwdata = {$urandom, $urandom}; dwe = 1'b1;
    for (int g = 0; g < 4; g++) begin
      first_d = tie_winner_d();
      serve(first_d, $urandom_range(0, 2), {$urandom, $urandom}, 1'b0);
    end
    ireq = 1'b0; dreq = 1'b0;
    tick();

    // Randomized single and colliding requests; a stray mack in IDLE must do nothing.
    for (int it = 0; it < 40; it++) begin
      ri = 1'($urandom % 2);
      rq = 1'($urandom % 2);
      if (!ri && !rq) ri = 1'b1;
      iadr = $urandom; dadr = {$urandom, $urandom}; dwdata = {$urandom, $urandom};
      dwe = 1'($urandom % 2);
      ireq = ri; dreq = rq;
      first_d = (ri && rq) ? tie_winner_d() : rq;
      serve(first_d, $urandom_range(0, 4), {$urandom, $urandom}, 1'b1);
      if (ri && rq) serve(!first_d, $urandom_range(0, 4), {$urandom, $urandom}, 1'b1);
      mack = 1'b1; mrdata = {$urandom, $urandom};
      tick();
      mack = 1'b0;
      check("idle_mack_mreq", mreq, 0);
      check("idle_mack_ready", {iready, dready}, 2'b00);
      check("idle_mack_drdata", drdata, m_drdata);
    end

    // Reset while a data access is in flight; the late mack must not produce a ready.
    dreq = 1'b1; dwe = 1'b1; dadr = {$urandom, $urandom}; dwdata = {$urandom, $urandom};
    tick();
    check("rstmid_mreq", mreq, 1);
    reset = 1'b1; dreq = 1'b0;
    tick();
    reset = 1'b0;
    mack = 1'b1; mrdata = {$urandom, $urandom};
    m_last_d = 1'b1; m_irdata = '0; m_drdata = '0;
    check("rstmid_mreq0", mreq, 0);
    check("rstmid_madr", madr, 0);
    tick();
    mack = 1'b0;
    check("rstmid_dready", dready, 0);
    check("rstmid_mreq1", mreq, 0);
    check("rstmid_drdata", drdata, 0);
    tick();
    check("rstmid_dready2", dready, 0);

    // After reset lastgrant is D, so a fair-mode tie goes to I first.
    ireq = 1'b1; iadr = $urandom; dreq = 1'b1; dadr = {$urandom, $urandom}; dwe = 1'b0;
    first_d = tie_winner_d();
    serve(first_d, 0, {$urandom, $urandom}, 1'b1);
    serve(!first_d, 1, {$urandom, $urandom}, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Hard time limit in case the design never responds.
  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter N, 64, data-port and memory data width.
REQ-002 SHALL have parameter W, 32, instruction and memory address width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports ireq input 1 / iadr input W  instruction fetch request and address.
REQ-006 SHALL have ports iready output 1 / irdata output W  fetch done pulse and instruction word.
REQ-007 SHALL have ports dreq input 1 / dwe input 1 / dadr input N / dwdata input N  data request, write enable, address, write data.
REQ-008 SHALL have ports dready output 1 / drdata output N  data done pulse and read data.
REQ-009 SHALL have ports mreq output 1 / mwe output 1 / madr output W / mwdata output N  shared memory request.
REQ-010 SHALL have ports mack input 1 / mrdata input N  memory acknowledge and read data, valid in the mack cycle.
REQ-011 SHALL have port stallF output 1, high when ireq is high and iready is low.
REQ-012 SHALL have port stallM output 1, high when dreq is high and dready is low.

Function
REQ-013 SHALL implement FSM states IDLE, IBUSY, DBUSY, RESP.
REQ-014 SHALL, in IDLE with dreq=1, go to DBUSY; with only ireq=1, go to IBUSY; with neither, stay in IDLE.
REQ-015 SHALL register madr/mwe/mwdata on the grant edge: madr=dadr[W-1:0], mwe=dwe, mwdata=dwdata for data; madr=iadr, mwe=0 for fetch.
REQ-016 SHALL drive mreq=1 only in IBUSY/DBUSY and hold madr/mwe/mwdata stable until mack.
REQ-017 SHALL, on mack=1 in IBUSY/DBUSY, capture mrdata (irdata=mrdata[W-1:0] or drdata=mrdata) and go to RESP.
REQ-018 SHALL, in RESP, pulse the served port's ready for exactly one cycle, grant nothing, and return to IDLE.
REQ-019 SHALL ignore mack in IDLE and RESP.
REQ-020 SHALL give a minimum access latency of 3 cycles from request to ready with zero-wait memory (mack in first BUSY cycle).
REQ-021 SHALL require requesters to hold req and the request fields until their ready pulse; a requester whose req drops before grant is not served.
REQ-022 SHALL hold irdata and drdata until the next capture on that port.
REQ-023 SHALL zero-extend nothing: drdata carries the full N bits; alignment and extension belong to the datapath.
REQ-024 SHALL keep a lastgrant register (I or D), updated on every grant.

Reset
REQ-025 SHALL, on reset=1 at a clock edge, enter IDLE and clear mreq, mwe, madr, mwdata, iready, dready, irdata, drdata to 0; lastgrant=D.
REQ-026 SHALL, on reset during IBUSY/DBUSY, abandon the access; a later mack SHALL produce no ready.

Configuration
REQ-027 SHALL use macro MEM_ARB_FAIR_EN.
REQ-028 SHALL, with MEM_ARB_FAIR_EN undefined, give the data port fixed priority on simultaneous ireq and dreq in IDLE.
REQ-029 SHALL, with MEM_ARB_FAIR_EN defined, grant the port not equal to lastgrant on simultaneous requests; single requests are granted directly.

Verification
REQ-030 SHALL test fetch: ireq=1, iadr=0x00000040, mack 1 cycle after mreq with mrdata=0x20080005 -> madr=0x40, mwe=0, iready pulses once, irdata=0x20080005.
REQ-031 SHALL test store: dreq=1, dwe=1, dadr=0x80, dwdata=0x1122334455667788 -> mwe=1, madr=0x80, mwdata held until mack, dready one pulse.
REQ-032 SHALL test collision without macro: ireq=dreq=1 together -> data served first, fetch granted in the IDLE after RESP, stallF high throughout.
REQ-033 SHALL test collision with MEM_ARB_FAIR_EN, both held high continuously -> grants alternate I, D, I, D (first tie goes to I).
REQ-034 SHALL test wait states: mack delayed 4 cycles -> mreq high and madr stable all 4 cycles, ready 1 cycle after mack.
REQ-035 SHALL test reset mid-access: reset in DBUSY, then mack=1 -> IDLE, mreq=0, no dready.
